// File: rtl/reg_pipe_elastic.sv
// ----------------------------------------------------------------------------
// reg_pipe_elastic: DEPTH-stage valid/ready pipeline register with sync flush.
// Optional per-stage parity when REG_PIPE_PARITY_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reg_pipe_elastic #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       out_par_err
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0]            rdy;
  logic [OCC_W-1:0]            occupancy_q, occupancy_d;
  logic                        in_xfer;
  logic                        out_xfer;

  // rdy[i]: stage i may load this cycle (empty, or everything ahead of it moves)
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc    = ~v_q[i] | acc;
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush & rst;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v_q[DEPTH-1] & out_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occupancy_q;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_xfer;
        if (in_xfer) data_d[0] = in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    occupancy_d = occupancy_q;
    if (flush) begin
      occupancy_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy_d = occupancy_q + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy_d = occupancy_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      data_q      <= {DEPTH{RST_VAL}};
      occupancy_q <= '0;
    end else begin
      v_q         <= v_d;
      data_q      <= data_d;
      occupancy_q <= occupancy_d;
    end
  end

`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] p_q, p_d;

  // Parity bits follow exactly the same load rule as their data words
  always_comb begin
    p_d = p_q;
    if (!flush) begin
      if (rdy[0] && in_xfer) p_d[0] = ^in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (rdy[i] && v_q[i-1]) p_d[i] = p_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign out_par_err = v_q[DEPTH-1] & (^data_q[DEPTH-1] ^ p_q[DEPTH-1]);
`else
  assign out_par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe_elastic.sv
// ----------------------------------------------------------------------------
// tb_reg_pipe_elastic: directed + random checks of two pipe instances (DEPTH 2/4)
// against a queue-of-items reference model. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reg_pipe_elastic;

  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl   [2];
  logic        iv   [2];
  logic        ordy [2];
  logic [31:0] id   [2];

  logic        ir2, ov2, pe2;
  logic [31:0] od2;
  logic [1:0]  occ2;
  logic        ir4, ov4, pe4;
  logic [31:0] od4;
  logic [2:0]  occ4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of in-flight items, each with its stage position
  int          dep    [2];
  logic [31:0] m_dat  [2][4];
  int          m_pos  [2][4];
  int          m_cnt  [2];
  logic [31:0] m_last [2];
  int          n_pos  [2][4];
  logic        n_pop  [2];
  logic        n_rdy  [2];

  logic [31:0] got [20];
  int          n_out;
  logic [31:0] hold_d;

  always #5 clk = ~clk;

  reg_pipe_elastic #(.WIDTH(32), .DEPTH(2), .RST_VAL(RV0)) u_d2 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir2), .in_data(id[0]),
    .out_valid(ov2), .out_ready(ordy[0]), .out_data(od2),
    .occupancy(occ2), .out_par_err(pe2)
  );

  reg_pipe_elastic #(.WIDTH(32), .DEPTH(4), .RST_VAL(RV1)) u_d4 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir4), .in_data(id[1]),
    .out_valid(ov4), .out_ready(ordy[1]), .out_data(od4),
    .occupancy(occ4), .out_par_err(pe4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u]  = 0;
      m_last[u] = (u == 0) ? RV0 : RV1;
    end
  endtask

  // Each item advances one stage unless it would collide with the item ahead
  task automatic plan(input int u);
    int lim;
    n_pop[u] = (m_cnt[u] > 0) && (m_pos[u][0] == dep[u] - 1) && ordy[u];
    lim = dep[u] - 1;
    for (int k = (n_pop[u] ? 1 : 0); k < m_cnt[u]; k++) begin
      n_pos[u][k] = (m_pos[u][k] + 1 < lim) ? m_pos[u][k] + 1 : lim;
      lim = n_pos[u][k] - 1;
    end
    n_rdy[u] = rst && !fl[u] && (lim >= 0);
  endtask

  task automatic update(input int u);
    int j;
    if (!rst) return;
    plan(u);
    if (fl[u]) begin
      m_cnt[u] = 0;
      return;
    end
    j = 0;
    for (int k = (n_pop[u] ? 1 : 0); k < m_cnt[u]; k++) begin
      m_dat[u][j] = m_dat[u][k];
      m_pos[u][j] = n_pos[u][k];
      j++;
    end
    if (iv[u] && n_rdy[u]) begin
      m_dat[u][j] = id[u];
      m_pos[u][j] = 0;
      j++;
    end
    m_cnt[u] = j;
    if (j > 0 && m_pos[u][0] == dep[u] - 1) m_last[u] = m_dat[u][0];
  endtask

  task automatic check(input int u);
    logic        o_ir, o_ov, o_pe;
    logic [31:0] o_od, o_occ;
    plan(u);
    if (u == 0) begin
      o_ir = ir2; o_ov = ov2; o_od = od2; o_pe = pe2; o_occ = 32'(occ2);
    end else begin
      o_ir = ir4; o_ov = ov4; o_od = od4; o_pe = pe4; o_occ = 32'(occ4);
    end
    chk($sformatf("u%0d_in_ready", u), 32'(o_ir), 32'(n_rdy[u]));
    chk($sformatf("u%0d_out_valid", u), 32'(o_ov),
        32'(m_cnt[u] > 0 && m_pos[u][0] == dep[u] - 1));
    chk($sformatf("u%0d_out_data", u), o_od, m_last[u]);
    chk($sformatf("u%0d_occupancy", u), o_occ, 32'(m_cnt[u]));
    chk($sformatf("u%0d_par_err", u), 32'(o_pe), 32'd0);
  endtask

  task automatic cycle();
    #1;
    check(0);
    check(1);
    @(posedge clk);
    update(0);
    update(1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    dep[0] = 2;
    dep[1] = 4;
    for (int u = 0; u < 2; u++) begin
      fl[u] = 1'b0; iv[u] = 1'b0; ordy[u] = 1'b1; id[u] = 32'h0;
    end
    #1 rst = 1'b0;
    mreset();

    // Reset state
    cycle();
    cycle();
    chk("rst_out_data", od2, RV0);
    chk("rst_occupancy", 32'(occ2), 32'd0);
    chk("rst_in_ready", 32'(ir2), 32'd0);
    chk("rst_out_data_d4", od4, RV1);
    rst = 1'b1;
    cycle();

    // Latency: DEPTH=2 cycles from accept to out_valid
    iv[0] = 1'b1; id[0] = 32'hDEAD_BEEF;
    cycle();
    iv[0] = 1'b0;
    cycle();
    chk("lat_valid", 32'(ov2), 32'd1);
    chk("lat_data", od2, 32'hDEAD_BEEF);
    cycle();

    // Back-pressure on the DEPTH=2 pipe
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 32'h1;
    cycle();
    id[0] = 32'h2;
    cycle();
    id[0] = 32'h3;
    #1;
    chk("bp_third_rejected", 32'(ir2), 32'd0);
    chk("bp_occupancy", 32'(occ2), 32'd2);
    chk("bp_out_hold", od2, 32'h1);
    cycle();
    cycle();
    chk("bp_stall_data", od2, 32'h1);
    ordy[0] = 1'b1;
    n_out = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) iv[0] = 1'b0;
      if (ov2) begin
        if (n_out < 20) got[n_out] = od2;
        n_out++;
      end
      cycle();
    end
    chk("bp_count", 32'(n_out), 32'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("bp_order%0d", k), got[k], 32'(k + 1));

    // Streaming 20 items through the DEPTH=4 pipe
    ordy[1] = 1'b1;
    n_out = 0;
    for (int i = 0; i < 24; i++) begin
      iv[1] = (i < 20);
      id[1] = 32'h100 + 32'(i);
      if (i >= 4 && i <= 20) chk($sformatf("stream_occ%0d", i), 32'(occ4), 32'd4);
      if (ov4) begin
        if (n_out < 20) got[n_out] = od4;
        n_out++;
      end
      cycle();
    end
    chk("stream_count", 32'(n_out), 32'd20);
    for (int k = 0; k < 20; k++) chk($sformatf("stream_seq%0d", k), got[k], 32'h100 + 32'(k));

    // Flush with occupancy 2 and in_valid held high
    ordy[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 32'hA1;
    cycle();
    id[1] = 32'hA2;
    cycle();
    id[1] = 32'hA3; fl[1] = 1'b1;
    hold_d = od4;
    #1;
    chk("flush_occ_before", 32'(occ4), 32'd2);
    chk("flush_in_ready", 32'(ir4), 32'd0);
    cycle();
    fl[1] = 1'b0; iv[1] = 1'b0;
    chk("flush_occ_after", 32'(occ4), 32'd0);
    chk("flush_valid_after", 32'(ov4), 32'd0);
    chk("flush_data_hold", od4, hold_d);
    cycle();

    // Asynchronous reset mid-stream with occupancy 3
    iv[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id[1] = 32'hB1 + 32'(k);
      cycle();
    end
    iv[1] = 1'b0;
    chk("areset_occ_before", 32'(occ4), 32'd3);
    #2 rst = 1'b0;
    mreset();
    #1;
    chk("areset_valid", 32'(ov4), 32'd0);
    chk("areset_occ", 32'(occ4), 32'd0);
    chk("areset_data", od4, RV1);
    cycle();
    rst = 1'b1;
    ordy[1] = 1'b1;
    cycle();

    // Randomised traffic on both pipes
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < 2; u++) begin
        iv[u]   = ($urandom_range(0, 3) != 0);
        id[u]   = $urandom;
        ordy[u] = ($urandom_range(0, 2) != 0);
        fl[u]   = ($urandom_range(0, 19) == 0);
      end
      cycle();
    end
    for (int u = 0; u < 2; u++) begin
      fl[u] = 1'b0; iv[u] = 1'b0; ordy[u] = 1'b1;
    end
    cycle();

`ifdef REG_PIPE_PARITY_EN
    rst = 1'b0;
    mreset();
    cycle();
    rst = 1'b1;
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 32'h0000_0007;
    cycle();
    iv[0] = 1'b0;
    cycle();
    chk("par_valid", 32'(ov2), 32'd1);
    chk("par_ok", 32'(pe2), 32'd0);
    force u_d2.data_q[1][0] = 1'b0;
    #1;
    chk("par_err_forced", 32'(pe2), 32'd1);
    release u_d2.data_q[1][0];
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
